// File: rtl/mode_sequencer.sv
// ============================================================================
// Module   : mode_sequencer
// Purpose  : Chooses the active LED pattern mode, either tracking the manual
//            request or cycling automatically on divider ticks.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mode_sequencer #(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tick,
   input  logic               auto_en,
   input  logic [1:0]         manual_mode,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               hold,
   output logic [1:0]         mode_sel,
   output logic [3:0]         mode_onehot,
   output logic               mode_restart,
   output logic [DWELL_W-1:0] dwell_left,
   output logic               running
);

   localparam logic [1:0] S_MANUAL = 2'd0;
   localparam logic [1:0] S_AUTO   = 2'd1;
   localparam logic [1:0] S_PAUSE  = 2'd2;

   logic [1:0]         r_state;
   logic [1:0]         r_mode_sel;
   logic [3:0]         r_mode_onehot;
   logic               r_mode_restart;
   logic [DWELL_W-1:0] r_dwell_left;
   logic               r_running;

   logic [1:0]         w_state_nxt;
   logic [1:0]         w_mode_nxt;
   logic               w_restart_nxt;
   logic [DWELL_W-1:0] w_left_nxt;
   logic [DWELL_W-1:0] w_eff;
   logic               w_last_tick;

   // A programmed dwell of zero would never expire, so it runs as one tick.
   assign w_eff       = (dwell == '0) ? DWELL_W'(1) : dwell;
   assign w_last_tick = (r_dwell_left == '0) || (r_dwell_left == DWELL_W'(1));

   always_comb begin
      w_state_nxt   = r_state;
      w_mode_nxt    = r_mode_sel;
      w_restart_nxt = 1'b0;
      w_left_nxt    = r_dwell_left;
      case (r_state)
         S_MANUAL: begin
            w_left_nxt = '0;
            if (auto_en) begin
               w_state_nxt = S_AUTO;
               w_left_nxt  = w_eff;
            end else if (manual_mode != r_mode_sel) begin
               w_mode_nxt    = manual_mode;
               w_restart_nxt = 1'b1;
            end
         end
         S_AUTO: begin
            if (!auto_en) begin
               w_state_nxt = S_MANUAL;
               w_left_nxt  = '0;
            end else if (hold) begin
               w_state_nxt = S_PAUSE;
            end else if (tick) begin
               if (w_last_tick) begin
                  w_mode_nxt    = r_mode_sel + 2'd1;
                  w_left_nxt    = w_eff;
                  w_restart_nxt = 1'b1;
               end else begin
                  w_left_nxt = r_dwell_left - DWELL_W'(1);
               end
            end
         end
         S_PAUSE: begin
            if (!auto_en) begin
               w_state_nxt = S_MANUAL;
               w_left_nxt  = '0;
            end else if (!hold) begin
               w_state_nxt = S_AUTO;
            end
         end
         default: begin
            w_state_nxt = S_MANUAL;
            w_left_nxt  = '0;
         end
      endcase
   end

   // Every output is a flop fed from next-state values, so none of them
   // has a combinational path from the inputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= S_MANUAL;
         r_mode_sel     <= 2'd0;
         r_mode_onehot  <= 4'b0001;
         r_mode_restart <= 1'b0;
         r_dwell_left   <= '0;
         r_running      <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_mode_sel     <= w_mode_nxt;
         r_mode_onehot  <= 4'b0001 << w_mode_nxt;
         r_mode_restart <= w_restart_nxt;
         r_dwell_left   <= w_left_nxt;
         r_running      <= (w_state_nxt == S_AUTO);
      end
   end

   assign mode_sel     = r_mode_sel;
   assign mode_onehot  = r_mode_onehot;
   assign mode_restart = r_mode_restart;
   assign dwell_left   = r_dwell_left;
   assign running      = r_running;

endmodule

`default_nettype wire

// File: tb/tb_mode_sequencer.sv
// ============================================================================
// Module   : tb_mode_sequencer
// Purpose  : Directed self-checking bench for mode_sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mode_sequencer;

   localparam int DWELL_W = 8;

   logic               clk;
   logic               reset;
   logic               tick;
   logic               auto_en;
   logic [1:0]         manual_mode;
   logic [DWELL_W-1:0] dwell;
   logic               hold;
   logic [1:0]         mode_sel;
   logic [3:0]         mode_onehot;
   logic               mode_restart;
   logic [DWELL_W-1:0] dwell_left;
   logic               running;

   int n_checks = 0;
   int n_pass   = 0;
   int exp_mode;
   int exp_left;
   int exp_dwell;

   mode_sequencer #(.DWELL_W(DWELL_W)) u_dut (
      .clk          (clk),
      .reset        (reset),
      .tick         (tick),
      .auto_en      (auto_en),
      .manual_mode  (manual_mode),
      .dwell        (dwell),
      .hold         (hold),
      .mode_sel     (mode_sel),
      .mode_onehot  (mode_onehot),
      .mode_restart (mode_restart),
      .dwell_left   (dwell_left),
      .running      (running)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One auto-mode tick followed by three idle clocks; exp_* track the spec.
   task automatic auto_tick(input string tag);
      tick = 1'b1;
      step();
      tick = 1'b0;
      if (exp_left <= 1) begin
         exp_mode = (exp_mode + 1) % 4;
         exp_left = (exp_dwell == 0) ? 1 : exp_dwell;
         check({tag, "_restart"}, int'(mode_restart), 1);
      end else begin
         exp_left = exp_left - 1;
         check({tag, "_restart"}, int'(mode_restart), 0);
      end
      check({tag, "_mode"}, int'(mode_sel), exp_mode);
      check({tag, "_onehot"}, int'(mode_onehot), 1 << exp_mode);
      check({tag, "_left"}, int'(dwell_left), exp_left);
      for (int i = 0; i < 3; i++) step();
      check({tag, "_idle_restart"}, int'(mode_restart), 0);
      check({tag, "_idle_mode"}, int'(mode_sel), exp_mode);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got 1 expected 0");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; tick = 1'b0; auto_en = 1'b0; manual_mode = 2'd0;
      dwell = 8'd3; hold = 1'b0;
      step();
      check("rst_mode", int'(mode_sel), 0);
      check("rst_onehot", int'(mode_onehot), 1);
      check("rst_restart", int'(mode_restart), 0);
      check("rst_left", int'(dwell_left), 0);
      check("rst_running", int'(running), 0);
      reset = 1'b0;
      step();
      check("post_rst_mode", int'(mode_sel), 0);

      // Manual tracking
      manual_mode = 2'd3;
      step();
      check("man_mode", int'(mode_sel), 3);
      check("man_onehot", int'(mode_onehot), 8);
      check("man_restart", int'(mode_restart), 1);
      step();
      check("man_restart_once", int'(mode_restart), 0);
      step();
      check("man_hold_restart", int'(mode_restart), 0);
      check("man_hold_mode", int'(mode_sel), 3);
      check("man_left", int'(dwell_left), 0);

      // Auto cycling from mode 1, dwell 3
      manual_mode = 2'd1;
      step();
      check("man1_restart", int'(mode_restart), 1);
      step();
      auto_en = 1'b1; dwell = 8'd3;
      step();
      check("auto_entry_running", int'(running), 1);
      check("auto_entry_left", int'(dwell_left), 3);
      check("auto_entry_mode", int'(mode_sel), 1);
      check("auto_entry_restart", int'(mode_restart), 0);
      exp_mode = 1; exp_left = 3; exp_dwell = 3;
      for (int t = 0; t < 12; t++) auto_tick("cyc");
      check("cyc_end_mode", int'(mode_sel), 1);

      // dwell=0 acts as 1; reload picks it up only after the current interval
      dwell = 8'd0; exp_dwell = 0;
      for (int t = 0; t < 3; t++) auto_tick("d0");
      check("d0_mode", int'(mode_sel), 2);
      check("d0_left", int'(dwell_left), 1);
      tick = 1'b1;
      for (int t = 0; t < 4; t++) begin
         step();
         exp_mode = (exp_mode + 1) % 4;
         check("b2b_mode", int'(mode_sel), exp_mode);
         check("b2b_restart", int'(mode_restart), 1);
         check("b2b_left", int'(dwell_left), 1);
      end
      tick = 1'b0;
      step();
      check("b2b_end_restart", int'(mode_restart), 0);
      check("b2b_end_mode", int'(mode_sel), 2);

      // Pause and priority
      dwell = 8'd3; exp_dwell = 3;
      auto_tick("pre_pause");
      auto_tick("pre_pause");
      check("pre_pause_left", int'(dwell_left), 2);
      check("pre_pause_mode", int'(mode_sel), 3);
      hold = 1'b1; tick = 1'b1;
      step();
      tick = 1'b0;
      check("pause_left", int'(dwell_left), 2);
      check("pause_running", int'(running), 0);
      check("pause_mode", int'(mode_sel), 3);
      tick = 1'b1;
      step();
      tick = 1'b0;
      check("pause_tick_left", int'(dwell_left), 2);
      hold = 1'b0;
      step();
      check("resume_running", int'(running), 1);
      check("resume_left", int'(dwell_left), 2);
      auto_tick("resume");
      auto_tick("resume");
      check("resume_adv_mode", int'(mode_sel), 0);
      auto_tick("prio");
      auto_tick("prio");
      check("prio_left1", int'(dwell_left), 1);
      manual_mode = 2'd0;
      auto_en = 1'b0; tick = 1'b1;
      step();
      tick = 1'b0;
      check("prio_mode", int'(mode_sel), 0);
      check("prio_restart", int'(mode_restart), 0);
      check("prio_running", int'(running), 0);
      check("prio_left", int'(dwell_left), 0);
      step();
      check("prio_manual_mode", int'(mode_sel), 0);

      // Leave auto at mode 2 with matching manual request
      manual_mode = 2'd2;
      step();
      check("m2_restart", int'(mode_restart), 1);
      auto_en = 1'b1;
      step();
      check("m2_auto_running", int'(running), 1);
      auto_en = 1'b0;
      step();
      check("exit_same_mode", int'(mode_sel), 2);
      check("exit_same_restart", int'(mode_restart), 0);
      step();
      check("exit_same_restart2", int'(mode_restart), 0);

      // Leave auto at mode 2 with a different manual request
      auto_en = 1'b1;
      step();
      manual_mode = 2'd0; auto_en = 1'b0;
      step();
      check("exit_diff_mode", int'(mode_sel), 2);
      check("exit_diff_restart0", int'(mode_restart), 0);
      step();
      check("exit_diff_mode2", int'(mode_sel), 0);
      check("exit_diff_restart", int'(mode_restart), 1);
      step();
      check("exit_diff_restart_off", int'(mode_restart), 0);

      // Asynchronous reset in AUTO at mode 2
      manual_mode = 2'd2;
      step();
      auto_en = 1'b1;
      step();
      check("pre_rst_mode", int'(mode_sel), 2);
      check("pre_rst_running", int'(running), 1);
      #2 reset = 1'b1;
      #1;
      check("arst_mode", int'(mode_sel), 0);
      check("arst_onehot", int'(mode_onehot), 1);
      check("arst_running", int'(running), 0);
      check("arst_left", int'(dwell_left), 0);
      check("arst_restart", int'(mode_restart), 0);
      manual_mode = 2'd0; auto_en = 1'b0;
      #1 reset = 1'b0;
      step();
      check("rel_running", int'(running), 0);
      check("rel_left", int'(dwell_left), 0);
      check("rel_mode", int'(mode_sel), 0);
      manual_mode = 2'd1;
      step();
      check("rel_manual_track", int'(mode_sel), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mode_sequencer.md
# mode_sequencer

Controller that decides which of the four LED pattern modes is active, replacing the direct switch-to-mode wiring when automatic cycling is wanted. In manual operation it tracks a 2-bit mode request. In auto operation it steps through modes 0→1→2→3→0, holding each mode for a programmable number of divider ticks. It drives the mode select, the one-hot mode-enable vector for the mode engines and HEX enables, and a restart strobe. It sits between the switch inputs/clock divider and the LED chooser and mode engines.

## Interface
- DWELL_W, default 8: width of the dwell counter and of the `dwell` input.
- clk  input  1  system clock (50 MHz board clock).
- reset  input  1  asynchronous, active-high reset.
- tick  input  1  one-cycle enable strobe from the clock divider, synchronous to clk.
- auto_en  input  1  1 = auto cycling, 0 = manual.
- manual_mode  input  2  requested mode in manual operation.
- dwell  input  DWELL_W  ticks per mode in auto; 0 is treated as 1.
- hold  input  1  freezes auto cycling (pause).
- mode_sel  output  2  active mode index.
- mode_onehot  output  4  one-hot decode of mode_sel; bit n = mode n.
- mode_restart  output  1  one-cycle pulse, asserted in the same cycle mode_sel takes a new value.
- dwell_left  output  DWELL_W  ticks remaining in the current mode (auto); 0 in manual.
- running  output  1  1 while in AUTO state.

## Operation
- States: MANUAL, AUTO, PAUSE. Reset state is MANUAL.
- Reset values: mode_sel=0, mode_onehot=4'b0001, mode_restart=0, dwell_left=0, running=0.
- Effective dwell: eff = (dwell==0) ? 1 : dwell.
- MANUAL
  - If manual_mode != mode_sel: load mode_sel ← manual_mode and pulse mode_restart.
  - dwell_left is held at 0.
  - auto_en=1 → AUTO. On entry, dwell_left ← eff and the mode is unchanged. No restart pulse is generated on entry.
- AUTO
  - auto_en=0 → MANUAL (highest priority). dwell_left ← 0 and mode_sel is unchanged that cycle.
  - Else if hold=1 → PAUSE. Any tick in that cycle is ignored.
  - Else on tick:
    - If dwell_left<=1: mode_sel ← mode_sel+1 (mod 4, so 3 wraps to 0), dwell_left ← eff, and mode_restart pulses.
    - Otherwise dwell_left ← dwell_left−1.
  - The `dwell` input is sampled only at reload. Changing it mid-interval affects the next interval.
- PAUSE
  - Counter and mode are frozen and ticks are ignored.
  - auto_en=0 → MANUAL (priority). Otherwise hold=0 → AUTO.
- Priority within one cycle: auto_en deassert > hold > tick.
- mode_onehot is always the exact decode of mode_sel, never 0 and never multi-hot.
- reset asserted mid-operation returns immediately (asynchronously) to the reset values and the MANUAL state.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Manual change: manual_mode sampled at edge k appears on mode_sel/mode_onehot after edge k, with mode_restart high for exactly that one cycle.
- Auto advance: the tick that takes dwell_left from 1 causes a mode change visible after the same clk edge that samples the tick.
- With dwell=N, each mode lasts exactly N ticks in steady auto operation. A full cycle through all four modes takes 4N ticks.
- auto_en 0→1: running=1 one cycle later, and dwell_left=eff.
- hold: running drops one cycle after hold is sampled high.
- mode_restart is never high for two consecutive cycles unless two consecutive mode changes occur. Auto changes can occur at most once per tick.

## Test plan
- Reset checks:
  - Assert reset mid-AUTO with mode_sel=2 → outputs immediately show mode_sel=0, mode_onehot=0001, running=0, dwell_left=0, mode_restart=0.
  - Release reset → state is MANUAL.
- Manual tracking:
  - auto_en=0, manual_mode 0→3 → one cycle later mode_sel=3, mode_onehot=1000, mode_restart=1 for exactly one cycle.
  - Hold manual_mode=3 → no further restart pulses.
- Auto cycling:
  - dwell=3, auto_en=1 from mode 1, one tick every 4 clks → mode order 1,2,3,0,1, each mode held for 3 ticks.
  - dwell_left sequence within each mode is 3,2,1.
  - One restart pulse per change.
- dwell=0 behaves as 1:
  - Mode advances on every tick.
  - Back-to-back ticks on consecutive clks → mode increments every cycle and mode_restart stays high across those cycles.
- Pause and priority:
  - In AUTO with dwell_left=2, assert hold together with a tick → dwell_left stays 2 and running=0.
  - Release hold, then 2 ticks → mode advances.
  - Then deassert auto_en in the same cycle as a tick at dwell_left=1 → no advance, state is MANUAL, dwell_left=0.
- Mode change on return to manual:
  - Leave AUTO at mode_sel=2 with manual_mode=2 → no restart pulse.
  - Leave AUTO at mode_sel=2 with manual_mode=0 → mode_sel=0 one cycle after entering MANUAL, with a single restart pulse.
